gpio_int_ctrl: RTL
==================

GPIO_INT_CTRL -- requirements
Module: gpio_int_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of GPIO lines.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchroniser flops (fixed at 2 for all latency figures below).
REQ-003 SHALL use one clock and a synchronous, active-low reset: port clk, the single clock, and port rstn, the synchronous active-low reset.
REQ-004 clk  input  1  sole clock; all flops rising-edge.
REQ-005 rstn  input  1  synchronous active-low reset.
REQ-006 portin  input  WIDTH  asynchronous GPIO pin levels.
REQ-007 int_en  input  WIDTH  per-bit interrupt enable.
REQ-008 int_type  input  WIDTH  per-bit type: 0 = level, 1 = edge.
REQ-009 int_pol  input  WIDTH  per-bit polarity: level 1 = high / 0 = low; edge 1 = rising / 0 = falling.
REQ-010 int_clr  input  WIDTH  per-bit single-cycle clear of a sticky edge interrupt.
REQ-011 gpioint  output  WIDTH  registered per-bit interrupt status.
REQ-012 combint  output  1  registered OR of gpioint.
REQ-013 irq_valid  output  1  service request to the CPU-side handler.
REQ-014 irq_id  output  4  index of the serviced line; valid while irq_valid = 1.
REQ-015 irq_ack  input  1  handler acknowledge; meaningful only while irq_valid = 1.

Function
REQ-016 portin SHALL pass through a 2-flop synchroniser (s); a previous-value register p SHALL hold s delayed by one cycle.
REQ-017 An edge event on bit i SHALL be s&~p when int_pol[i]=1 and ~s&p when int_pol[i]=0.
REQ-018 Edge-type bits SHALL be sticky: set on an event when int_en[i]=1; cleared by int_clr[i], or by irq_ack when irq_id=i.
REQ-019 When a set and a clear occur on the same bit in the same cycle, the set SHALL win.
REQ-020 Level-type bits SHALL follow the input each cycle (int_en[i] & (int_pol[i] ? s[i] : ~s[i])); int_clr and irq_ack SHALL have no effect on them.
REQ-021 int_en[i]=0 SHALL force gpioint[i] to 0 on the next edge and discard any sticky state.
REQ-022 Latency: a portin change first sampled at edge 0 SHALL appear on gpioint after edge 2; combint SHALL appear after edge 3.
REQ-023 The FSM SHALL have three states: IDLE, PRESENT and GAP.
REQ-024 IDLE: when gpioint != 0, SHALL latch irq_id = lowest set index and assert irq_valid on the next edge, entering PRESENT.
REQ-025 PRESENT: irq_valid=1 and irq_id SHALL be held stable until irq_ack is seen, then the FSM SHALL enter GAP.
REQ-026 PRESENT: if gpioint[irq_id] falls without an ack, irq_valid SHALL drop on the next edge and the FSM SHALL return to IDLE (withdraw).
REQ-027 GAP: irq_valid=0 for exactly one cycle, then the FSM SHALL return to IDLE; this gives the acked edge bit one cycle to clear before re-arbitration.
REQ-028 An irq_ack received while irq_valid=0 SHALL be ignored.
REQ-029 A held level interrupt that is acked SHALL be re-presented after GAP if still asserted.
REQ-030 Changing int_type or int_pol SHALL take effect on the next edge and SHALL NOT clear existing sticky bits.

Reset
REQ-031 rstn=0 at a clock edge SHALL clear s, p, sticky bits, gpioint, combint, irq_valid and irq_id to 0, and SHALL place the FSM in IDLE, including mid-operation in PRESENT or GAP.
REQ-032 After reset, a portin bit already high SHALL produce a rising-edge event once synchronised (s and p reset to 0); this behaviour is required, not suppressed.

Verification
REQ-033 Edge latency: int_en=0x0001, int_type=0x0001, int_pol=0x0001, portin[0] 0->1 at edge 0 -> gpioint=0x0001 after edge 2, combint=1 after edge 3, irq_valid=1 with irq_id=0 after edge 3.
REQ-034 Priority and ack: bits 3 and 9 rising-edge pending together -> irq_id=3; irq_ack -> bit 3 clears, one GAP cycle, then irq_id=9 presented.
REQ-035 Level re-present: bit 5 level-high, portin[5] held 1, irq_ack -> irq_valid low for one cycle, then irq_id=5 again; portin[5]=0 -> withdraw within 3 cycles, gpioint=0.
REQ-036 Set/clear collision: int_clr[2]=1 in the same cycle as a new falling edge on bit 2 (int_pol[2]=0) -> gpioint[2] remains 1.
REQ-037 Withdraw: in PRESENT with irq_id=7, int_en[7] set to 0 -> gpioint[7]=0 next edge, irq_valid=0 the edge after, FSM in IDLE.
REQ-038 Reset mid-PRESENT: rstn=0 for one edge -> all outputs 0; then portin=0xFFFF with all bits rising-edge enabled -> gpioint=0xFFFF after edge 2 and irq_id=0.

Source files
------------

// File: rtl/gpio_int_ctrl_if.sv
// GPIO interrupt bus: pin levels, per-bit interrupt configuration, status and the
// CPU-side service handshake.
// Handshake: irq_valid and irq_id are held stable until the cycle in which
// irq_ack is 1, which completes the transfer; irq_ack while irq_valid=0 is ignored.
interface gpio_int_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] portin;
  logic [WIDTH-1:0] int_en;
  logic [WIDTH-1:0] int_type;
  logic [WIDTH-1:0] int_pol;
  logic [WIDTH-1:0] int_clr;
  logic [WIDTH-1:0] gpioint;
  logic             combint;
  logic             irq_valid;
  logic [3:0]       irq_id;
  logic             irq_ack;

  modport master (
    output portin, int_en, int_type, int_pol, int_clr, irq_ack,
    input  gpioint, combint, irq_valid, irq_id
  );

  modport slave (
    input  portin, int_en, int_type, int_pol, int_clr, irq_ack,
    output gpioint, combint, irq_valid, irq_id
  );
endinterface

// File: rtl/gpio_int_ctrl.sv
// GPIO interrupt controller: synchronises pins, detects level/edge interrupts and
// presents the lowest pending line to a handler over a valid/ack handshake.
module gpio_int_ctrl #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  gpio_int_ctrl_if.slave        gif,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [WIDTH-1:0] gpioint_q, gpioint_d;
  logic             combint_q;
  logic             irq_valid_q;
  logic [3:0]       irq_id_q, irq_id_d;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] lvl;
  logic [WIDTH-1:0] set_v;
  logic [WIDTH-1:0] clr_v;
  logic [WIDTH-1:0] ack_mask;
  logic             ack_fire;
  logic [3:0]       first_id;

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_evt = (gif.int_pol & s & ~prev_q) | (~gif.int_pol & ~s & prev_q);
  assign lvl      = ~(gif.int_pol ^ s);
  assign ack_fire = (state_q == PRESENT) && gif.irq_ack;
  assign ack_mask = ack_fire ? (WIDTH'(1) << irq_id_q) : '0;

  // Clears are masked by type so level bits keep any hidden sticky state intact
  // across a later switch back to edge mode; a same-cycle set beats a clear.
  assign set_v     = gif.int_en & gif.int_type & edge_evt;
  assign clr_v     = (gif.int_clr | ack_mask) & gif.int_type;
  assign sticky_d  = gif.int_en & (set_v | (sticky_q & ~clr_v));
  assign gpioint_d = gif.int_en & ((gif.int_type & sticky_d) | (~gif.int_type & lvl));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q      <= '0;
      sticky_q    <= '0;
      gpioint_q   <= '0;
      combint_q   <= 1'b0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      state_q     <= IDLE;
    end else begin
      sync_q[0] <= gif.portin;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q      <= s;
      sticky_q    <= sticky_d;
      gpioint_q   <= gpioint_d;
      combint_q   <= |gpioint_q;
      irq_valid_q <= (state_d == PRESENT);
      irq_id_q    <= irq_id_d;
      state_q     <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    first_id = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (gpioint_q[i]) first_id = 4'(i);
    end
    case (state_q)
      IDLE: begin
        if (|gpioint_q) begin
          state_d  = PRESENT;
          irq_id_d = first_id;
        end
      end
      PRESENT: begin
        // An ack outranks a simultaneous withdraw.
        if (gif.irq_ack)                state_d = GAP;
        else if (!gpioint_q[irq_id_q])  state_d = IDLE;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gif.gpioint   = gpioint_q;
  assign gif.combint   = combint_q;
  assign gif.irq_valid = irq_valid_q;
  assign gif.irq_id    = irq_id_q;
  assign state_o       = state_q;

endmodule
